// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default widths, partial-sum
// type and constant helper functions used to size counters and saturation limits.
package conv_pkg;

    localparam int DEF_BW2 = 19;
    localparam int DEF_AW  = 22;
    localparam int DEF_OW  = 8;

    typedef logic signed [DEF_BW2-1:0] psum_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Signed OW-bit range: upper limit when want_hi is set, lower limit otherwise.
    function automatic longint sat_limits(input int ow, input bit want_hi);
        longint one;
        one = 1;
        return want_hi ? ((one <<< (ow - 1)) - one) : -(one <<< (ow - 1));
    endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// Synchronous FIFO, DEPTH x W, head read straight from flop storage; a push
// while full is accepted only when a pop frees the slot in the same cycle.
module conv_sync_fifo
    import conv_pkg::*;
#(
    parameter int W     = DEF_OW,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == (PW+1)'(DEPTH));
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; the count gates visibility, so stale entries never reach o_data.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_psum_collector.sv
// Accumulates K row partial sums per pixel, round-shift requantizes, saturates
// to OW bits and queues results. Optional bias input: define CONV_PSUM_BIAS_EN.
module conv_psum_collector
    import conv_pkg::*;
#(
    parameter int BW2   = DEF_BW2,
    parameter int K     = 5,
    parameter int AW    = DEF_AW,
    parameter int OW    = DEF_OW,
    parameter int SW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic signed [BW2-1:0]   i_psum,
    input  logic [SW-1:0]           i_shift,
`ifdef CONV_PSUM_BIAS_EN
    input  logic signed [AW-1:0]    i_bias,
`endif
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [OW-1:0]           o_data,
    output logic [cnt_width(K)-1:0] o_row_cnt,
    output logic                    o_overflow
);

    localparam int RCW = cnt_width(K);
`ifdef CONV_PSUM_BIAS_EN
    localparam int SUMW = AW + 1;
`else
    localparam int SUMW = AW;
`endif
    localparam int RW = SUMW + 1;
    localparam logic signed [RW-1:0] SAT_HI = RW'(sat_limits(OW, 1'b1));
    localparam logic signed [RW-1:0] SAT_LO = RW'(sat_limits(OW, 1'b0));

    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [SUMW-1:0] sum_next;
    logic [RCW-1:0]         row_cnt;
    logic                   last_row;
    logic [SW-1:0]          shift_clamped;

    logic                   rq_valid;
    logic signed [SUMW-1:0] rq_sum;
    logic [SW-1:0]          rq_shift;

    logic signed [RW-1:0]   rnd;
    logic signed [RW-1:0]   biased;
    logic signed [RW-1:0]   rounded;
    logic [OW-1:0]          pixel;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;

    assign acc_next = acc + AW'(i_psum);
`ifdef CONV_PSUM_BIAS_EN
    assign sum_next = SUMW'(acc) + SUMW'(i_psum) + SUMW'(i_bias);
`else
    assign sum_next = acc_next;
`endif
    assign last_row      = (row_cnt == RCW'(K - 1));
    assign shift_clamped = (int'(i_shift) > AW - 1) ? SW'(AW - 1) : i_shift;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc      <= '0;
            row_cnt  <= '0;
            rq_valid <= 1'b0;
            rq_sum   <= '0;
            rq_shift <= '0;
        end else if (i_clear) begin
            acc      <= '0;
            row_cnt  <= '0;
            rq_valid <= 1'b0;
        end else begin
            rq_valid <= i_valid && last_row;
            if (i_valid) begin
                if (last_row) begin
                    acc      <= '0;
                    row_cnt  <= '0;
                    rq_sum   <= sum_next;
                    rq_shift <= shift_clamped;
                end else begin
                    acc     <= acc_next;
                    row_cnt <= row_cnt + RCW'(1);
                end
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        rnd     = '0;
        biased  = '0;
        rounded = '0;
        pixel   = '0;
        if (rq_shift != '0) begin
            rnd = RW'(1) <<< (rq_shift - SW'(1));
        end
        biased  = RW'(rq_sum) + rnd;
        rounded = biased >>> rq_shift;
        if (rounded > SAT_HI) begin
            pixel = SAT_HI[OW-1:0];
        end else if (rounded < SAT_LO) begin
            pixel = SAT_LO[OW-1:0];
        end else begin
            pixel = rounded[OW-1:0];
        end
    end

    assign push = rq_valid && !i_clear;

    conv_sync_fifo #(
        .W     (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_push  (push),
        .i_data  (pixel),
        .i_pop   (i_ready),
        .o_data  (o_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // A full FIFO only drops the pixel when no pop frees a slot in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_overflow <= 1'b0;
        end else if (push && fifo_full && !i_ready) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_valid   = !fifo_empty;
    assign o_row_cnt = row_cnt;

endmodule

// File: tb/tb_conv_psum_collector.sv
// Randomized and directed bench for conv_psum_collector against a queue-based
// reference model of pixel accumulation, requantization and output buffering.
module tb_conv_psum_collector;

    localparam int BW2   = 19;
    localparam int K     = 5;
    localparam int AW    = 22;
    localparam int OW    = 8;
    localparam int SW    = 5;
    localparam int DEPTH = 4;

    logic                  i_clk;
    logic                  i_rst_n;
    logic                  i_clear;
    logic                  i_valid;
    logic signed [BW2-1:0] i_psum;
    logic [SW-1:0]         i_shift;
`ifdef CONV_PSUM_BIAS_EN
    logic signed [AW-1:0]  i_bias;
`endif
    logic                  o_valid;
    logic                  i_ready;
    logic [OW-1:0]         o_data;
    logic [2:0]            o_row_cnt;
    logic                  o_overflow;

    int n_vec;
    int n_fail;

    // Reference model state: psums of the pixel in progress, pixels awaiting
    // their FIFO slot, the FIFO contents and the sticky overflow flag.
    int row_q[$];
    int exp_q[$];
    bit pend_v;
    int pend_px;
    bit ovf;

    conv_psum_collector #(
        .BW2   (BW2),
        .K     (K),
        .AW    (AW),
        .OW    (OW),
        .SW    (SW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_valid    (i_valid),
        .i_psum     (i_psum),
        .i_shift    (i_shift),
`ifdef CONV_PSUM_BIAS_EN
        .i_bias     (i_bias),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_row_cnt  (o_row_cnt),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Round half toward +inf via floor division, then clamp to the OW-bit range.
    function automatic int requant(input longint sum, input int sh);
        int     s;
        longint d;
        longint num;
        longint q;
        s = (sh > AW - 1) ? AW - 1 : sh;
        if (s == 0) begin
            q = sum;
        end else begin
            d   = longint'(2) ** s;
            num = sum + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0)) q = q - 1;
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic model_reset();
        row_q.delete();
        exp_q.delete();
        pend_v = 1'b0;
        pend_px = 0;
        ovf = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int ps, input int sh, input bit rdy, input bit clr);
        longint sum;
        if (clr) begin
            model_reset();
            return;
        end
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (pend_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(pend_px);
            else ovf = 1'b1;
        end
        pend_v = 1'b0;
        if (v) begin
            row_q.push_back(ps);
            if (row_q.size() == K) begin
                sum = 0;
                foreach (row_q[i]) sum += row_q[i];
                pend_px = requant(sum, sh);
                pend_v = 1'b1;
                row_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("o_valid", o_valid, exp_q.size() != 0);
        check("o_data", $signed(o_data), (exp_q.size() != 0) ? exp_q[0] : 0);
        check("o_row_cnt", o_row_cnt, row_q.size());
        check("o_overflow", o_overflow, ovf);
    endtask

    task automatic step(input bit v, input int ps, input int sh, input bit rdy, input bit clr);
        i_valid = v;
        i_psum  = ps[BW2-1:0];
        i_shift = sh[SW-1:0];
        i_ready = rdy;
        i_clear = clr;
        @(posedge i_clk);
        model_edge(v, ps, sh, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic send5(input int p0, input int p1, input int p2, input int p3, input int p4,
                         input int sh, input bit rdy);
        step(1'b1, p0, sh, rdy, 1'b0);
        step(1'b1, p1, sh, rdy, 1'b0);
        step(1'b1, p2, sh, rdy, 1'b0);
        step(1'b1, p3, sh, rdy, 1'b0);
        step(1'b1, p4, sh, rdy, 1'b0);
    endtask

    // Push a pixel through with i_ready high and check the head one cycle after the push.
    task automatic pixel_check(input string tag, input int p0, input int sh, input int exp);
        send5(p0, 0, 0, 0, 0, sh, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check(tag, $signed(o_data), exp);
    endtask

    task automatic async_reset();
        #3;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int ps;
        int sh;
        n_vec = 0;
        n_fail = 0;
        i_rst_n = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_psum  = '0;
        i_shift = '0;
        i_ready = 1'b0;
`ifdef CONV_PSUM_BIAS_EN
        i_bias  = '0;
`endif
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_row_cnt", o_row_cnt, 0);
        check("rst_overflow", o_overflow, 0);
        i_rst_n = 1'b1;

        // Basic accumulation with two-cycle latency.
        send5(10, 20, 30, 40, -3, 0, 1'b1);
        check("lat_not_yet", o_valid, 0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("lat_t2_valid", o_valid, 1);
        check("pix_97", $signed(o_data), 97);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Rounding and saturation.
        pixel_check("round_5_s1", 5, 1, 3);
        pixel_check("round_m5_s1", -5, 1, -2);
        pixel_check("round_6_s2", 6, 2, 2);
        send5(100, 100, 100, 100, 100, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("sat_hi", $signed(o_data), 127);
        send5(-100, -100, -100, -100, -100, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("sat_lo", $signed(o_data), -128);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Backpressure: six pixels into a four-entry FIFO.
        for (int i = 1; i <= 6; i++) send5(i, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) step(1'b0, 0, 0, 1'b0, 1'b0);
        check("bp_overflow", o_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check("bp_drain", $signed(o_data), i);
            step(1'b0, 0, 0, 1'b1, 1'b0);
        end
        check("bp_drain_empty", o_valid, 0);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        check("clear_overflow", o_overflow, 0);

        // Full FIFO with push and pop on the same edge.
        for (int i = 11; i <= 14; i++) send5(i, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) step(1'b0, 0, 0, 1'b0, 1'b0);
        send5(15, 0, 0, 0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("pushpop_overflow", o_overflow, 0);
        check("pushpop_head", $signed(o_data), 12);
        n = 0;
        while (o_valid && n < 10) begin
            step(1'b0, 0, 0, 1'b1, 1'b0);
            n++;
        end
        check("pushpop_count", n, 4);

        // Clear mid-pixel with a simultaneous valid, then a fresh pixel.
        step(1'b1, 7, 0, 1'b1, 1'b0);
        step(1'b1, 7, 0, 1'b1, 1'b0);
        step(1'b1, 999, 0, 1'b1, 1'b1);
        check("clear_row_cnt", o_row_cnt, 0);
        send5(1, 2, 3, 4, 5, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("after_clear_pix", $signed(o_data), 15);

        // Asynchronous reset mid-pixel.
        step(1'b1, 50, 0, 1'b1, 1'b0);
        step(1'b1, 50, 0, 1'b1, 1'b0);
        async_reset();
        check("areset_row_cnt", o_row_cnt, 0);
        send5(2, 2, 2, 2, 2, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("after_areset_pix", $signed(o_data), 10);

        // Randomized traffic, including wide psums and shifts past the clamp.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) ps = int'($urandom_range(0, 524287)) - 262144;
            else ps = int'($urandom_range(0, 400)) - 200;
            sh = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            step($urandom_range(0, 9) < 7, ps, sh, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
